// File: rtl/ir_pkg.sv
// Shared constants, instruction word type and long-opcode decode for the prefetch queue.
// Optional macro IR_LONG_INSTR_EN enables two-word instructions.
package ir_pkg;

  localparam int INSTR_W_DEF  = 8;
  localparam int OPCODE_W_DEF = 4;

`ifdef IR_LONG_INSTR_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef logic [INSTR_W_DEF-1:0] instr_t;

  // op is the zero-extended opcode field, w its real width; only its MSB matters.
  function automatic logic is_long_opcode(input logic [31:0] op, input int unsigned w);
    return LONG_EN && op[w-1];
  endfunction

endpackage

// File: rtl/ir_prefetch_if.sv
// Memory-to-prefetch-queue word handshake (valid/ready).
interface ir_prefetch_if #(
  parameter int INSTR_W = 8
);
  logic               in_valid;
  logic [INSTR_W-1:0] in_data;
  logic               in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ir_fifo.sv
// Circular instruction buffer with single or double pop and a head+1 peek port.
// The second peek port and pop2 exist only under IR_LONG_INSTR_EN.
module ir_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     data,
  input  logic             pop1,
`ifdef IR_LONG_INSTR_EN
  input  logic             pop2,
  output logic [W-1:0]     head_next,
`endif
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       pop_n;

  assign head = mem[rd_ptr];
`ifdef IR_LONG_INSTR_EN
  assign head_next = mem[rd_ptr + PTR_W'(1)];
  assign pop_n     = pop2 ? 2'd2 : {1'b0, pop1};
`else
  assign pop_n     = {1'b0, pop1};
`endif

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

endmodule

// File: rtl/ir_prefetch.sv
// Instruction prefetch queue feeding a decoded instruction register, with branch flush.
// Optional macro IR_LONG_INSTR_EN: opcode MSB=1 marks a two-word instruction.
module ir_prefetch
  import ir_pkg::*;
#(
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int DEPTH    = 4,
  localparam int ADDR_W  = INSTR_W - OPCODE_W,
  localparam int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                reset_n,
  ir_prefetch_if.slave        mem,
  input  logic                ir_write,
  input  logic                flush,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   address_field,
  output logic [INSTR_W-1:0]  ext_operand,
  output logic                long_instr,
  output logic                ir_valid,
  output logic                instr_avail,
  output logic [CNT_W-1:0]    q_count
);

  logic               push;
  logic               load;
  logic               pop1;
  logic [INSTR_W-1:0] head;

  assign mem.in_ready = !flush && (q_count < CNT_W'(DEPTH));
  assign push         = mem.in_valid && mem.in_ready;
  assign load         = ir_write && instr_avail && !flush;

`ifdef IR_LONG_INSTR_EN
  logic               head_long;
  logic               pop2;
  logic [INSTR_W-1:0] head_next;

  assign head_long   = is_long_opcode(32'(head[INSTR_W-1 -: OPCODE_W]), OPCODE_W);
  assign instr_avail = head_long ? (q_count >= CNT_W'(2)) : (q_count >= CNT_W'(1));
  assign pop1        = load && !head_long;
  assign pop2        = load && head_long;
`else
  assign instr_avail = (q_count >= CNT_W'(1));
  assign pop1        = load;
  assign ext_operand = '0;
  assign long_instr  = 1'b0;
`endif

  ir_fifo #(
    .W     (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .data      (mem.in_data),
    .pop1      (pop1),
`ifdef IR_LONG_INSTR_EN
    .pop2      (pop2),
    .head_next (head_next),
`endif
    .head      (head),
    .count     (q_count)
  );

  // Flush wins over ir_write; a request with nothing complete at the head is a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opcode        <= '0;
      address_field <= '0;
      ir_valid      <= 1'b0;
`ifdef IR_LONG_INSTR_EN
      ext_operand   <= '0;
      long_instr    <= 1'b0;
`endif
    end else if (flush) begin
      ir_valid <= 1'b0;
    end else if (ir_write) begin
      if (instr_avail) begin
        opcode        <= head[INSTR_W-1 -: OPCODE_W];
        address_field <= head[ADDR_W-1:0];
        ir_valid      <= 1'b1;
`ifdef IR_LONG_INSTR_EN
        ext_operand   <= head_long ? head_next : '0;
        long_instr    <= head_long;
`endif
      end else begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ir_prefetch.sv
// Scoreboard bench for ir_prefetch: a queue-based reference model predicts IR loads,
// a separate monitor compares the IR outputs after every ir_write or flush.
module tb_ir_prefetch;
  import ir_pkg::*;

  localparam int DEPTH = 4;
`ifdef IR_LONG_INSTR_EN
  localparam bit LONG = 1'b1;
`else
  localparam bit LONG = 1'b0;
`endif

  typedef struct {
    logic [3:0] op;
    logic [3:0] addr;
    logic [7:0] ext;
    logic       lng;
    logic       vld;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ir_write = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] opcode;
  logic [3:0] address_field;
  logic [7:0] ext_operand;
  logic       long_instr;
  logic       ir_valid;
  logic       instr_avail;
  logic [2:0] q_count;

  int vectors = 0;
  int miscompares = 0;

  instr_t model_q[$];
  exp_t   sb[$];
  exp_t   m_ir = '{op: 4'h0, addr: 4'h0, ext: 8'h00, lng: 1'b0, vld: 1'b0};

  ir_prefetch_if #(.INSTR_W(8)) bus ();

  ir_prefetch #(.INSTR_W(8), .OPCODE_W(4), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem           (bus),
    .ir_write      (ir_write),
    .flush         (flush),
    .opcode        (opcode),
    .address_field (address_field),
    .ext_operand   (ext_operand),
    .long_instr    (long_instr),
    .ir_valid      (ir_valid),
    .instr_avail   (instr_avail),
    .q_count       (q_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational status, advance the model.
  task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic w, input logic f);
    bit rdy, hl, av;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    ir_write     = w;
    flush        = f;
    rdy = !f && (model_q.size() < DEPTH);
    hl  = LONG && (model_q.size() > 0) && model_q[0][7];
    av  = (model_q.size() >= (hl ? 2 : 1));
    #1;
    check_output("in_ready", 32'(bus.in_ready), 32'(rdy));
    check_output("instr_avail", 32'(instr_avail), 32'(av));
    check_output("q_count", 32'(q_count), model_q.size());
    if (f) begin
      model_q.delete();
      m_ir.vld = 1'b0;
    end else begin
      if (w) begin
        if (av) begin
          m_ir.op   = model_q[0][7:4];
          m_ir.addr = model_q[0][3:0];
          m_ir.ext  = hl ? model_q[1] : 8'h00;
          m_ir.lng  = hl;
          m_ir.vld  = 1'b1;
          void'(model_q.pop_front());
          if (hl) void'(model_q.pop_front());
        end else begin
          m_ir.vld = 1'b0;
        end
      end
      if (v && rdy) model_q.push_back(d);
    end
    if (w || f) sb.push_back(m_ir);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    ir_write     = 1'b0;
    flush        = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_output("rst_opcode", 32'(opcode), 0);
    check_output("rst_address", 32'(address_field), 0);
    check_output("rst_ext", 32'(ext_operand), 0);
    check_output("rst_long", 32'(long_instr), 0);
    check_output("rst_ir_valid", 32'(ir_valid), 0);
    check_output("rst_q_count", 32'(q_count), 0);
    model_q.delete();
    sb.delete();
    m_ir = '{op: 4'h0, addr: 4'h0, ext: 8'h00, lng: 1'b0, vld: 1'b0};
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("rst_in_ready", 32'(bus.in_ready), 1);
  endtask

  // Monitor: every ir_write or flush seen at an edge produces one IR comparison.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset_n && (ir_write || flush)) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL sb_underflow: IR update with no expectation at %0t", $time);
        end else begin
          e = sb.pop_front();
          check_output("opcode", 32'(opcode), 32'(e.op));
          check_output("address_field", 32'(address_field), 32'(e.addr));
          check_output("ext_operand", 32'(ext_operand), 32'(e.ext));
          check_output("long_instr", 32'(long_instr), 32'(e.lng));
          check_output("ir_valid", 32'(ir_valid), 32'(e.vld));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    do_reset();

    // Reset with three words queued.
    apply_stimulus(1, 8'h11, 0, 0);
    apply_stimulus(1, 8'h22, 0, 0);
    apply_stimulus(1, 8'h33, 0, 0);
    do_reset();

    // Single short instruction, then a bubble on the empty queue.
    apply_stimulus(1, 8'h3A, 0, 0);
    apply_stimulus(0, 8'h00, 1, 0);
    apply_stimulus(0, 8'h00, 1, 0);
    apply_stimulus(0, 8'h00, 0, 0);

    // Fill to full, then hold a fifth word while popping across the pointer wrap.
    apply_stimulus(1, 8'h41, 0, 0);
    apply_stimulus(1, 8'h52, 0, 0);
    apply_stimulus(1, 8'h63, 0, 0);
    apply_stimulus(1, 8'h04, 0, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(1, 8'h77, 1, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 8'h00, 1, 0);

    // Long instruction split across two pushes.
    apply_stimulus(1, 8'h9C, 0, 0);
    apply_stimulus(0, 8'h00, 1, 0);
    apply_stimulus(1, 8'h55, 0, 0);
    apply_stimulus(0, 8'h00, 1, 0);

    // Flush together with in_valid and ir_write on a three-word queue.
    apply_stimulus(1, 8'h2B, 0, 0);
    apply_stimulus(0, 8'h00, 1, 0);
    apply_stimulus(1, 8'h12, 0, 0);
    apply_stimulus(1, 8'h34, 0, 0);
    apply_stimulus(1, 8'h56, 0, 0);
    apply_stimulus(1, 8'hEE, 1, 1);
    apply_stimulus(0, 8'h00, 0, 0);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      apply_stimulus($urandom_range(9, 0) < 6, 8'($urandom),
                     $urandom_range(9, 0) < 4, $urandom_range(15, 0) == 0);
    end

    apply_stimulus(0, 8'h00, 0, 0);
    apply_stimulus(0, 8'h00, 0, 0);
    check_output("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
